pci_bus_arbiter: RTL and testbench

Central arbiter for the shared PCI-style bus: it accepts one active-low `request` line from each attached `device`, and drives one active-low `grant` line back to each. It watches `iframe`/`iready` to track bus ownership and hands the bus to exactly one initiator at a time. It is the stage that produces the `grant` consumed by every device and consumes the `request` each device produces.

---
 rtl/pci_bus_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_pci_bus_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter
//   Central arbiter for a shared PCI-style bus. Takes one active-low request
//   per device, returns one active-low grant per device, and follows
//   iframe/iready to track ownership so only one initiator owns the bus.
//
//   Optional feature macro: PCI_ARB_ROUND_ROBIN_EN
//     defined   -> rotating priority; search starts at a pointer that moves
//                  to winner+1 after every grant
//     undefined -> fixed priority, lowest requesting index wins
//
// Ports
//   clk       in            bus clock, all state updates on posedge
//   rst_n     in            asynchronous active-low reset
//   request   in  [N_DEV]   per-device request, active low
//   iframe    in            bus frame, active low
//   iready    in            initiator ready, active low
//   grant     out [N_DEV]   per-device grant, active low, at most one low
//   owner     out [OWNER_W] index of current / last granted device
//   bus_busy  out           high while in GRANTED, BUSY or DRAIN
module pci_bus_arbiter #(
    parameter int unsigned N_DEV        = 4,
    parameter int unsigned OWNER_W      = 2,
    parameter int unsigned PARK_TIMEOUT = 16,
    parameter int unsigned MAX_TENURE   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_DEV-1:0]   request,
    input  logic               iframe,
    input  logic               iready,
    output logic [N_DEV-1:0]   grant,
    output logic [OWNER_W-1:0] owner,
    output logic               bus_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        BUSY    = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam logic [7:0] PARK_LIM   = 8'(PARK_TIMEOUT);
    localparam logic [7:0] TENURE_LIM = 8'(MAX_TENURE);

    state_t               state, state_nx;
    logic [N_DEV-1:0]     grant_nx;
    logic [N_DEV-1:0]     win_grant;
    logic [OWNER_W-1:0]   owner_nx;
    logic [OWNER_W-1:0]   winner;
    logic [7:0]           park_cnt, park_nx, park_inc;
    logic [7:0]           tenure, tenure_nx, tenure_inc;
    logic                 any_req;
    logic                 owner_req_off;
    logic                 other_req;
    logic                 bus_idle;

    assign any_req       = ~&request;
    assign owner_req_off = (request[owner] == 1'b1);
    // X/Z on either line must not be taken as an idle bus.
    assign bus_idle      = (iframe == 1'b1) && (iready == 1'b1);

`ifdef PCI_ARB_ROUND_ROBIN_EN
    logic [OWNER_W-1:0] ptr;
    logic [OWNER_W-1:0] ptr_nx;
    logic [OWNER_W-1:0] win_hi, win_lo;
    logic               found_hi, found_lo;

    // Two passes folded into one loop: the first requester at or above the
    // pointer wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int unsigned i = 0; i < N_DEV; i++) begin
            if (request[i] == 1'b0) begin
                if (!found_lo) begin
                    win_lo   = OWNER_W'(i);
                    found_lo = 1'b1;
                end
                if (!found_hi && (OWNER_W'(i) >= ptr)) begin
                    win_hi   = OWNER_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    assign ptr_nx = (winner == OWNER_W'(N_DEV - 1)) ? '0 : winner + OWNER_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if ((state == IDLE) && any_req) begin
            ptr <= ptr_nx;
        end
    end
`else
    logic win_found;

    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < N_DEV; i++) begin
            if ((request[i] == 1'b0) && !win_found) begin
                winner    = OWNER_W'(i);
                win_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        win_grant = '1;
        other_req = 1'b0;
        for (int unsigned i = 0; i < N_DEV; i++) begin
            win_grant[i] = (OWNER_W'(i) != winner);
            if ((request[i] == 1'b0) && (OWNER_W'(i) != owner)) begin
                other_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        grant_nx   = grant;
        owner_nx   = owner;
        park_nx    = park_cnt;
        tenure_nx  = tenure;
        park_inc   = park_cnt + 8'd1;
        tenure_inc = (tenure == 8'hFF) ? tenure : tenure + 8'd1;

        case (state)
            IDLE: begin
                grant_nx = '1;
                if (any_req) begin
                    grant_nx  = win_grant;
                    owner_nx  = winner;
                    park_nx   = '0;
                    tenure_nx = '0;
                    state_nx  = GRANTED;
                end
            end
            GRANTED: begin
                // iframe has priority over a simultaneous request release.
                if (iframe == 1'b0) begin
                    state_nx = BUSY;
                end else if (owner_req_off) begin
                    grant_nx = '1;
                    state_nx = IDLE;
                end else begin
                    park_nx = park_inc;
                    if (park_inc == PARK_LIM) begin
                        grant_nx = '1;
                        state_nx = IDLE;
                    end
                end
            end
            BUSY: begin
                tenure_nx = tenure_inc;
                if (owner_req_off ||
                    ((MAX_TENURE != 0) && (tenure_inc >= TENURE_LIM) && other_req)) begin
                    grant_nx = '1;
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                grant_nx = '1;
                if (bus_idle) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                grant_nx = '1;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '1;
            owner    <= '0;
            bus_busy <= 1'b0;
            park_cnt <= '0;
            tenure   <= '0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            owner    <= owner_nx;
            bus_busy <= (state_nx != IDLE);
            park_cnt <= park_nx;
            tenure   <= tenure_nx;
        end
    end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed self-checking bench for pci_bus_arbiter (4 devices, park timeout
// 16, tenure limit 8). Works with or without PCI_ARB_ROUND_ROBIN_EN.
module tb_pci_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] request;
    logic       iframe;
    logic       iready;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       bus_busy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    logic [3:0]  grant_prev = 4'hF;
    logic [3:0]  req_prev   = 4'hF;
    int unsigned exp_order [5];
    logic [3:0]  eg;

    always #5 clk = ~clk;

    pci_bus_arbiter #(
        .N_DEV       (4),
        .OWNER_W     (2),
        .PARK_TIMEOUT(16),
        .MAX_TENURE  (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .request (request),
        .iframe  (iframe),
        .iready  (iready),
        .grant   (grant),
        .owner   (owner),
        .bus_busy(bus_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Snapshot values that the next rising edge will decide on.
    always @(negedge clk) begin
        grant_prev = grant;
        req_prev   = request;
    end

    // Every cycle: at most one grant low, and a newly lowered grant bit must
    // belong to a device that was requesting at the deciding edge.
    always @(posedge clk) begin
        #1;
        check("grant_onehot0", 32'($countones(~grant) <= 1), 32'd1);
        check("grant_to_requester", 32'(grant_prev & ~grant & req_prev), 32'd0);
    end

    initial begin
`ifdef PCI_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        rst_n   = 1'b1;
        request = 4'b1111;
        iframe  = 1'b1;
        iready  = 1'b1;
        #1 rst_n = 1'b0;
        tick();
        check("rst_grant", 32'(grant), 32'hF);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_busy", 32'(bus_busy), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_no_req", 32'(grant), 32'hF);

        // Park timeout: device 0 granted, never drives iframe.
        request = 4'b1110;
        tick();
        check("t1_grant", 32'(grant), 32'b1110);
        check("t1_owner", 32'(owner), 32'd0);
        check("t1_busy", 32'(bus_busy), 32'd1);
        for (int i = 0; i < 15; i++) tick();
        check("t1_park_15", 32'(grant), 32'b1110);
        tick();
        check("t1_park_rev", 32'(grant), 32'hF);
        check("t1_park_busy", 32'(bus_busy), 32'd0);
        request = 4'b1111;
        tick();
        check("t1_idle", 32'(grant), 32'hF);
        check("t1_owner_hold", 32'(owner), 32'd0);

        // Transaction by device 1, release, drain, then device 3.
        request = 4'b0101;
        tick();
        check("t2_grant", 32'(grant), 32'b1101);
        check("t2_owner", 32'(owner), 32'd1);
        iframe  = 1'b0;
        request = 4'b1101;
        tick();
        check("t2_busy_grant", 32'(grant), 32'b1101);
        for (int i = 0; i < 9; i++) tick();
        check("t2_busy_hold", 32'(grant), 32'b1101);
        request = 4'b0111;
        tick();
        check("t2_release", 32'(grant), 32'hF);
        check("t2_drain_busy", 32'(bus_busy), 32'd1);
        tick();
        tick();
        check("t2_drain_hold", 32'(grant), 32'hF);
        iframe = 1'b1;
        iready = 1'b0;
        tick();
        check("t2_drain_iready", 32'(bus_busy), 32'd1);
        check("t2_drain_grant", 32'(grant), 32'hF);
        iready = 1'b1;
        tick();
        check("t2_idle_grant", 32'(grant), 32'hF);
        check("t2_idle_busy", 32'(bus_busy), 32'd0);
        check("t2_idle_owner", 32'(owner), 32'd1);
        tick();
        check("t2_next_grant", 32'(grant), 32'b0111);
        check("t2_next_owner", 32'(owner), 32'd3);
        request = 4'b1111;
        tick();
        check("t2_done", 32'(grant), 32'hF);

        // Everyone requesting; each owner drops its request once granted.
        for (int k = 0; k < 5; k++) begin
            request = 4'b0000;
            tick();
            eg = ~(4'b0001 << exp_order[k]);
            check("t3_order_grant", 32'(grant), 32'(eg));
            check("t3_order_owner", 32'(owner), exp_order[k]);
            request = 4'b0001 << exp_order[k];
            tick();
            check("t3_order_rel", 32'(grant), 32'hF);
        end
        request = 4'b1111;
        tick();

        // Tenure limit: device 2 holds iframe low while device 3 waits.
        request = 4'b1011;
        tick();
        check("t4_grant", 32'(grant), 32'b1011);
        check("t4_owner", 32'(owner), 32'd2);
        iframe  = 1'b0;
        request = 4'b0011;
        tick();
        for (int i = 0; i < 7; i++) tick();
        check("t4_busy7", 32'(grant), 32'b1011);
        tick();
        check("t4_tenure_rev", 32'(grant), 32'hF);
        check("t4_drain_busy", 32'(bus_busy), 32'd1);
        request = 4'b0111;
        tick();
        check("t4_drain_hold", 32'(grant), 32'hF);
        iframe = 1'b1;
        tick();
        check("t4_idle", 32'(grant), 32'hF);
        tick();
        check("t4_dev3_grant", 32'(grant), 32'b0111);
        check("t4_dev3_owner", 32'(owner), 32'd3);

        // Asynchronous reset mid-BUSY.
        request = 4'b1111;
        tick();
        check("t5_idle", 32'(grant), 32'hF);
        request = 4'b1101;
        tick();
        check("t5_grant", 32'(grant), 32'b1101);
        iframe = 1'b0;
        tick();
        check("t5_busy", 32'(bus_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_grant", 32'(grant), 32'hF);
        check("t5_async_owner", 32'(owner), 32'd0);
        check("t5_async_busy", 32'(bus_busy), 32'd0);
        iframe  = 1'b1;
        request = 4'b0000;
        #2 rst_n = 1'b1;
        tick();
        check("t5_restart_grant", 32'(grant), 32'b1110);
        check("t5_restart_owner", 32'(owner), 32'd0);
        request = 4'b1111;
        tick();
        check("t5_end", 32'(grant), 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
